// File: rtl/wmul_pkg.sv
// wmul_pkg: shared width, FSM state type and round-robin pick for wallace_mul_arbiter
package wmul_pkg;
   localparam int WMUL_WIDTH = 8;
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESP} wmul_state_t;
   // first valid index at or after (last+1) mod n; lower k wins, so scan k downward
   function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] last, input int n);
      logic [2:0] g;
      logic [2:0] idx;
      g = '0;
      for (int k = n; k >= 1; k--) begin
         idx = 3'((int'(last) + k) % n);
         if (valid[idx]) g = idx;
      end
      return g;
   endfunction
endpackage

// File: rtl/wallace_multiplier_top.sv
// wallace_multiplier_top: combinational signed 8x8 multiplier, partial products reduced by a 3:2 carry-save tree
module wallace_multiplier_top (
   input  logic signed [7:0]  A,
   input  logic signed [7:0]  B,
   output logic signed [15:0] PRODUCT
);
   logic [15:0] a_ext;
   logic [15:0] pp [8];
   logic [31:0] l1a, l1b, l2a, l2b, l3, l4;
   function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      logic [15:0] c;
      c = ((x & y) | (x & z) | (y & z)) << 1;
      return {c, x ^ y ^ z};
   endfunction
   assign a_ext = {{8{A[7]}}, A};
   // B's msb carries weight -128, so its row is subtracted
   always_comb begin
      for (int i = 0; i < 7; i++) pp[i] = B[i] ? a_ext << i : '0;
      pp[7] = B[7] ? -(a_ext << 7) : '0;
   end
   assign l1a = csa(pp[0], pp[1], pp[2]);
   assign l1b = csa(pp[3], pp[4], pp[5]);
   assign l2a = csa(l1a[15:0], l1a[31:16], l1b[15:0]);
   assign l2b = csa(l1b[31:16], pp[6], pp[7]);
   assign l3  = csa(l2a[15:0], l2a[31:16], l2b[15:0]);
   assign l4  = csa(l3[15:0], l3[31:16], l2b[31:16]);
   assign PRODUCT = l4[15:0] + l4[31:16];
endmodule

// File: rtl/wallace_mul_arbiter.sv
// wallace_mul_arbiter: round-robin sharing of one Wallace multiplier among NUM_REQ requesters
// optional WMUL_PERF_EN adds a 16-bit completed-op counter port perf_cnt
module wallace_mul_arbiter
   import wmul_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = WMUL_WIDTH,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [IDW-1:0]             rsp_id,
   output logic [2*WIDTH-1:0]         rsp_product,
   output logic                       busy
`ifdef WMUL_PERF_EN
   ,output logic [15:0]               perf_cnt
`endif
);
   wmul_state_t state, state_nxt;
   logic [IDW-1:0] last_grant, grant, id_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2*WIDTH-1:0] prod, prod_q;
   logic acc, done;
   assign grant = IDW'(rr_pick(8'(req_valid), 3'(last_grant), NUM_REQ));
   assign acc = (state == S_IDLE) && |req_valid;
   assign done = (state == S_RESP) && rsp_ready;
   wallace_multiplier_top u_mul (.A(a_q), .B(b_q), .PRODUCT(prod));
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = (state == S_IDLE) ? (acc ? S_MUL : S_IDLE) :
                  (state == S_MUL)  ? S_RESP :
                  (done ? S_IDLE : S_RESP);
   end
   always_comb begin
      req_ready = acc ? NUM_REQ'(1) << grant : '0;
      rsp_valid = state == S_RESP;
      busy = state != S_IDLE;
   end
   assign rsp_id = id_q;
   assign rsp_product = prod_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= IDW'(NUM_REQ - 1);
         id_q <= '0;
         a_q <= '0;
         b_q <= '0;
         prod_q <= '0;
      end else begin
         if (acc) begin
            a_q <= req_a[grant*WIDTH +: WIDTH];
            b_q <= req_b[grant*WIDTH +: WIDTH];
            id_q <= grant;
            last_grant <= grant;
         end
         if (state == S_MUL) prod_q <= prod;
      end
   end
`ifdef WMUL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) perf_cnt <= '0;
      else if (done) perf_cnt <= perf_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// tb_wallace_mul_arbiter: directed and randomized checks against a transaction-level model
module tb_wallace_mul_arbiter;
   localparam int N = 4;
   localparam int W = 8;
   logic clk = 0;
   logic rst;
   logic [N-1:0] req_valid, req_ready;
   logic [N*W-1:0] req_a, req_b;
   logic rsp_valid, rsp_ready, busy;
   logic [1:0] rsp_id;
   logic [15:0] rsp_product;
`ifdef WMUL_PERF_EN
   logic [15:0] perf_cnt;
`endif
   logic signed [7:0] opa [N];
   logic signed [7:0] opb [N];
   int total = 0, bad = 0, last = N - 1, ops = 0;

   wallace_mul_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy)
`ifdef WMUL_PERF_EN
      , .perf_cnt(perf_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ops;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = opa[i];
         req_b[i*W +: W] = opb[i];
      end
   endtask

   function automatic int ref_grant(input logic [N-1:0] v, input int lst);
      for (int k = 1; k <= N; k++)
         if (v[(lst + k) % N]) return (lst + k) % N;
      return -1;
   endfunction

   // one full transaction: accept, MUL, RESP held for d cycles, then consumed
   task automatic op(input logic [N-1:0] v, input int d);
      int g;
      logic [15:0] p;
      g = ref_grant(v, last);
      p = 16'(int'(opa[g]) * int'(opb[g]));
      drive_ops();
      req_valid = v;
      rsp_ready = 0;
      #1;
      chk("grant", 32'(req_ready), 32'(1 << g));
      tick();
      req_valid = '0;
      last = g;
      chk("mul_busy", 32'(busy), 1);
      chk("mul_rv", 32'(rsp_valid), 0);
      chk("mul_rdy", 32'(req_ready), 0);
      tick();
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_id", 32'(rsp_id), 32'(g));
      chk("rsp_prod", 32'(rsp_product), 32'(p));
      for (int i = 0; i < d; i++) begin
         req_valid = v;
         tick();
         chk("hold_rv", 32'(rsp_valid), 1);
         chk("hold_id", 32'(rsp_id), 32'(g));
         chk("hold_prod", 32'(rsp_product), 32'(p));
         chk("hold_rdy", 32'(req_ready), 0);
         chk("hold_busy", 32'(busy), 1);
      end
      req_valid = '0;
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      ops++;
      chk("done_rv", 32'(rsp_valid), 0);
      chk("done_busy", 32'(busy), 0);
`ifdef WMUL_PERF_EN
      chk("perf", 32'(perf_cnt), 32'(ops));
`endif
   endtask

   initial begin
      int g;
      rst = 1;
      req_valid = '0;
      rsp_ready = 0;
      req_a = '0;
      req_b = '0;
      repeat (2) tick();
      rst = 0;
      chk("rst_rv", 32'(rsp_valid), 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_prod", 32'(rsp_product), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rdy", 32'(req_ready), 0);
`ifdef WMUL_PERF_EN
      chk("rst_perf", 32'(perf_cnt), 0);
`endif
      tick();
      chk("idle_busy", 32'(busy), 0);
      // single request: 10 * -1
      opa[0] = 10; opb[0] = -1;
      op(4'b0001, 0);
      // round robin with all requesters valid
      opa[0] = 5;   opb[0] = 3;
      opa[1] = -8;  opb[1] = 6;
      opa[2] = -10; opb[2] = 10;
      opa[3] = 7;   opb[3] = 120;
      repeat (5) op(4'b1111, 0);
      // corners on one-hot requesters
      opa[1] = -128; opb[1] = 1;    op(4'b0010, 0);
      opa[2] = -128; opb[2] = -128; op(4'b0100, 0);
      opa[3] = 127;  opb[3] = 127;  op(4'b1000, 0);
      opa[0] = 0;    opb[0] = -5;   op(4'b0001, 0);
      // lone requester back-to-back, then backpressure
      op(4'b0001, 0);
      op(4'b1010, 5);
      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < N; i++) begin
            opa[i] = 8'($urandom);
            opb[i] = 8'($urandom);
         end
         op(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
      end
      // reset while in MUL discards the op; req 0 wins afterwards
      drive_ops();
      req_valid = 4'b1111;
      #1;
      g = ref_grant(req_valid, last);
      chk("pre_rst_grant", 32'(req_ready), 32'(1 << g));
      tick();
      chk("pre_rst_busy", 32'(busy), 1);
      rst = 1;
      tick();
      rst = 0;
      last = N - 1;
      ops = 0;
      chk("mrst_rv", 32'(rsp_valid), 0);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_grant", 32'(req_ready), 1);
`ifdef WMUL_PERF_EN
      chk("mrst_perf", 32'(perf_cnt), 0);
`endif
      req_valid = '0;
      tick();
      chk("mrst_norsp", 32'(rsp_valid), 0);
      op(4'b1111, 0);
      op(4'b1111, 1);
      op(4'b0110, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
